// File: rtl/rv_pkg.sv
// Shared types for the RV core: hazard-control output bundle and register-file size.
package rv_pkg;

    localparam int RV_NREGS = 32;

    typedef struct packed {
        logic hold_pipe;
        logic stall_if_id;
        logic bubble_id_ex;
        logic flush_if_id;
        logic flush_id_ex;
    } hazard_ctrl_t;

endpackage

// File: rtl/rv_hazard_scoreboard.sv
// Per-register load-latency countdown scoreboard. x0 never reports busy.
module rv_hazard_scoreboard
    import rv_pkg::*;
#(
    parameter int  NREGS    = RV_NREGS,
    parameter int  LOAD_LAT = 1,
    localparam int RW       = $clog2(NREGS),
    localparam int CW       = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_issue,
    input  logic [RW-1:0] i_rd,
    input  logic          i_hold,
    input  logic [RW-1:0] i_rs1,
    input  logic [RW-1:0] i_rs2,
    output logic          o_rs1_busy,
    output logic          o_rs2_busy
);

    logic [CW-1:0] sb_q [NREGS];
    logic [CW-1:0] sb_d [NREGS];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            sb_d[r] = sb_q[r];
            if (r == 0) begin
                sb_d[r] = '0;
            end else if (i_issue && (i_rd == RW'(r))) begin
                sb_d[r] = CW'(LOAD_LAT);
            end else if (!i_hold && (sb_q[r] != '0)) begin
                sb_d[r] = sb_q[r] - CW'(1);
            end
        end
    end

    // NOTE: this array is a bank of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                sb_q[r] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    assign o_rs1_busy = (sb_q[i_rs1] != '0);
    assign o_rs2_busy = (sb_q[i_rs2] != '0);

endmodule

// File: rtl/rv_hazard_ctrl.sv
// Hazard/stall/flush controller for the 5-stage RV core.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module rv_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int  NREGS        = RV_NREGS,
    parameter int  LOAD_LAT     = 1,
    parameter int  REDIRECT_LAT = 2,
    parameter int  PERF_W       = 32,
    localparam int RW           = $clog2(NREGS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [RW-1:0]     i_id_rs1,
    input  logic [RW-1:0]     i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [RW-1:0]     i_id_rd,
    input  logic              i_id_mem_read,
    input  logic              i_ex_do_branch,
    input  logic              i_mem_busy,
    output logic              o_hold_pipe,
    output logic              o_stall_if_id,
    output logic              o_bubble_id_ex,
    output logic              o_flush_if_id,
    output logic              o_flush_id_ex,
    output logic [PERF_W-1:0] o_perf_stall_cnt,
    output logic [PERF_W-1:0] o_perf_flush_cnt
);

    hazard_ctrl_t ctrl;
    logic         hold;
    logic         flush_act;
    logic         luse;
    logic         issue;
    logic         rs1_busy;
    logic         rs2_busy;
    logic [2:0]   fcnt_q;
    logic [2:0]   fcnt_d;

    assign hold      = i_mem_busy & ~i_rst;
    assign flush_act = (i_ex_do_branch | (fcnt_q != 3'd0)) & ~hold;
    assign luse      = i_id_valid &
                       ((i_id_rs1_used & (i_id_rs1 != '0) & rs1_busy) |
                        (i_id_rs2_used & (i_id_rs2 != '0) & rs2_busy));

    // Priority: reset > hold > flush > stall. A stall under a flush is dropped: that instruction is wrong-path.
    always_comb begin
        ctrl = '0;
        if (i_rst) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end else if (hold) begin
            ctrl.hold_pipe = 1'b1;
        end else if (flush_act) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end else begin
            ctrl.stall_if_id  = luse;
            ctrl.bubble_id_ex = luse;
        end
    end

    assign o_hold_pipe    = ctrl.hold_pipe;
    assign o_stall_if_id  = ctrl.stall_if_id;
    assign o_bubble_id_ex = ctrl.bubble_id_ex;
    assign o_flush_if_id  = ctrl.flush_if_id;
    assign o_flush_id_ex  = ctrl.flush_id_ex;

    // Only a load that actually leaves ID marks its destination.
    assign issue = i_id_valid & i_id_mem_read & (i_id_rd != '0) &
                   ~ctrl.hold_pipe & ~ctrl.flush_id_ex & ~ctrl.bubble_id_ex;

    rv_hazard_scoreboard #(
        .NREGS    (NREGS),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_issue    (issue),
        .i_rd       (i_id_rd),
        .i_hold     (hold),
        .i_rs1      (i_id_rs1),
        .i_rs2      (i_id_rs2),
        .o_rs1_busy (rs1_busy),
        .o_rs2_busy (rs2_busy)
    );

    always_comb begin
        fcnt_d = fcnt_q;
        if (i_ex_do_branch && !hold) begin
            fcnt_d = 3'(REDIRECT_LAT - 1);
        end else if ((fcnt_q != 3'd0) && !hold) begin
            fcnt_d = fcnt_q - 3'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fcnt_q <= 3'd0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;
    logic [PERF_W-1:0] flush_cnt_q;
    logic [PERF_W-1:0] flush_cnt_d;

    // Saturating counters: they stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ctrl.stall_if_id && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
        if (ctrl.flush_if_id && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_perf_stall_cnt = stall_cnt_q;
    assign o_perf_flush_cnt = flush_cnt_q;
`else
    assign o_perf_stall_cnt = '0;
    assign o_perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Directed bench for rv_hazard_ctrl: table-driven vectors on a LOAD_LAT=1 instance,
// hand-written multi-cycle sequences on a LOAD_LAT=3 / PERF_W=2 instance.
module tb_rv_hazard_ctrl;
    import rv_pkg::*;

`ifdef HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct {
        in_t          stim;
        hazard_ctrl_t want;
    } vec_t;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    in_t   in_a;
    in_t   in_b;
    int    n_err    = 0;
    int    n_checks = 0;

    logic        a_hold, a_stall, a_bub, a_fif, a_fid;
    logic        b_hold, b_stall, b_bub, b_fif, b_fid;
    logic [31:0] a_pstall, a_pflush;
    logic [1:0]  b_pstall, b_pflush;

    rv_hazard_ctrl #(.NREGS(32), .LOAD_LAT(1), .REDIRECT_LAT(2), .PERF_W(32)) dut_a (
        .i_clk(clk), .i_rst(in_a.rst), .i_id_valid(in_a.valid),
        .i_id_rs1(in_a.rs1), .i_id_rs2(in_a.rs2),
        .i_id_rs1_used(in_a.u1), .i_id_rs2_used(in_a.u2),
        .i_id_rd(in_a.rd), .i_id_mem_read(in_a.mr),
        .i_ex_do_branch(in_a.br), .i_mem_busy(in_a.busy),
        .o_hold_pipe(a_hold), .o_stall_if_id(a_stall), .o_bubble_id_ex(a_bub),
        .o_flush_if_id(a_fif), .o_flush_id_ex(a_fid),
        .o_perf_stall_cnt(a_pstall), .o_perf_flush_cnt(a_pflush)
    );

    rv_hazard_ctrl #(.NREGS(32), .LOAD_LAT(3), .REDIRECT_LAT(2), .PERF_W(2)) dut_b (
        .i_clk(clk), .i_rst(in_b.rst), .i_id_valid(in_b.valid),
        .i_id_rs1(in_b.rs1), .i_id_rs2(in_b.rs2),
        .i_id_rs1_used(in_b.u1), .i_id_rs2_used(in_b.u2),
        .i_id_rd(in_b.rd), .i_id_mem_read(in_b.mr),
        .i_ex_do_branch(in_b.br), .i_mem_busy(in_b.busy),
        .o_hold_pipe(b_hold), .o_stall_if_id(b_stall), .o_bubble_id_ex(b_bub),
        .o_flush_if_id(b_fif), .o_flush_id_ex(b_fid),
        .o_perf_stall_cnt(b_pstall), .o_perf_flush_cnt(b_pflush)
    );

    function automatic in_t mk(input logic rst, valid, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic mr, br, busy);
        in_t v;
        v = '{rst: rst, valid: valid, rs1: rs1, u1: u1, rs2: rs2, u2: u2,
              rd: rd, mr: mr, br: br, busy: busy};
        return v;
    endfunction

    function automatic hazard_ctrl_t ex(input logic h, s, f);
        hazard_ctrl_t e;
        e = '{hold_pipe: h, stall_if_id: s, bubble_id_ex: s, flush_if_id: f, flush_id_ex: f};
        return e;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    endfunction

    function automatic in_t ld(input logic [4:0] rd);
        return mk(0, 1, 5'd1, 1, 5'd0, 0, rd, 1, 0, 0);
    endfunction

    function automatic in_t use_rs1(input logic [4:0] rs);
        return mk(0, 1, rs, 1, 5'd0, 0, 5'd6, 0, 0, 0);
    endfunction

    function automatic hazard_ctrl_t got_a();
        hazard_ctrl_t g;
        g = '{hold_pipe: a_hold, stall_if_id: a_stall, bubble_id_ex: a_bub,
              flush_if_id: a_fif, flush_id_ex: a_fid};
        return g;
    endfunction

    function automatic hazard_ctrl_t got_b();
        hazard_ctrl_t g;
        g = '{hold_pipe: b_hold, stall_if_id: b_stall, bubble_id_ex: b_bub,
              flush_if_id: b_fif, flush_id_ex: b_fid};
        return g;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Drive at the negedge, compare 1 ns later, then advance one full cycle.
    task automatic cyc_a(input in_t v, input hazard_ctrl_t e, input string name);
        in_a = v;
        #1;
        check(name, 64'(got_a()), 64'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc_b(input in_t v, input hazard_ctrl_t e, input string name);
        in_b = v;
        #1;
        check(name, 64'(got_b()), 64'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        int   exp_stall;
        int   exp_flush;
        int   n_stall;
        int   n_hold;
        in_t  v;

        in_a = mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
        in_b = mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);

        // rst, valid, rs1, u1, rs2, u2, rd, mr, br, busy  ->  hold, stall/bubble, flush
        vecs.push_back('{mk(1,0, 5'd0,0, 5'd0,0, 5'd0, 0,0,1), ex(0,0,1)});  // reset beats busy
        vecs.push_back('{idle(),                               ex(0,0,0)});
        vecs.push_back('{ld(5'd5),                             ex(0,0,0)});  // load x5
        vecs.push_back('{mk(0,1, 5'd5,1, 5'd1,1, 5'd6, 0,0,0), ex(0,1,0)});  // add x6,x5,x1
        vecs.push_back('{mk(0,1, 5'd5,1, 5'd1,1, 5'd6, 0,0,0), ex(0,0,0)});
        vecs.push_back('{ld(5'd0),                             ex(0,0,0)});  // load x0
        vecs.push_back('{mk(0,1, 5'd0,1, 5'd0,1, 5'd3, 0,0,0), ex(0,0,0)});
        vecs.push_back('{ld(5'd5),                             ex(0,0,0)});
        vecs.push_back('{mk(0,1, 5'd1,1, 5'd5,0, 5'd6, 0,0,0), ex(0,0,0)});  // rs2=x5 unused
        vecs.push_back('{ld(5'd9),                             ex(0,0,0)});
        vecs.push_back('{mk(0,1, 5'd1,1, 5'd9,1, 5'd6, 0,0,0), ex(0,1,0)});  // rs2 hazard
        vecs.push_back('{ld(5'd11),                            ex(0,0,0)});
        vecs.push_back('{mk(0,0, 5'd11,1, 5'd0,0, 5'd0, 0,0,0),ex(0,0,0)});  // ID not valid
        vecs.push_back('{ld(5'd12),                            ex(0,0,0)});
        vecs.push_back('{mk(0,1, 5'd12,1, 5'd0,0, 5'd13, 1,1,0),ex(0,0,1)}); // branch beats luse
        vecs.push_back('{idle(),                               ex(0,0,1)});
        vecs.push_back('{use_rs1(5'd13),                       ex(0,0,0)});  // killed load left no mark
        vecs.push_back('{mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,1,0), ex(0,0,1)});
        vecs.push_back('{mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,1,0), ex(0,0,1)});  // reload
        vecs.push_back('{idle(),                               ex(0,0,1)});
        vecs.push_back('{idle(),                               ex(0,0,0)});
        vecs.push_back('{mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,1,0), ex(0,0,1)});
        vecs.push_back('{mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,0,1), ex(1,0,0)});  // busy mid-flush
        vecs.push_back('{idle(),                               ex(0,0,1)});  // flush resumes
        vecs.push_back('{idle(),                               ex(0,0,0)});
        vecs.push_back('{ld(5'd14),                            ex(0,0,0)});
        vecs.push_back('{mk(0,1, 5'd14,1, 5'd0,0, 5'd6, 0,0,1),ex(1,0,0)});  // hold beats stall
        vecs.push_back('{use_rs1(5'd14),                       ex(0,1,0)});
        vecs.push_back('{use_rs1(5'd14),                       ex(0,0,0)});
        vecs.push_back('{mk(0,1, 5'd1,1, 5'd0,0, 5'd15, 1,0,1),ex(1,0,0)});  // load under hold
        vecs.push_back('{use_rs1(5'd15),                       ex(0,0,0)});
        vecs.push_back('{mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,1,1), ex(1,0,0)});  // branch under hold
        vecs.push_back('{idle(),                               ex(0,0,0)});

        @(negedge clk);
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            cyc_a(vecs[i].stim, vecs[i].want, $sformatf("vec%0d", i));
            if (i > 0) begin
                exp_stall += int'(vecs[i].want.stall_if_id);
                exp_flush += int'(vecs[i].want.flush_if_id);
            end
        end
        check("a_perf_stall", 64'(a_pstall), PERF_ON ? 64'(exp_stall) : 64'd0);
        check("a_perf_flush", 64'(a_pflush), PERF_ON ? 64'(exp_flush) : 64'd0);

        // LOAD_LAT=3 instance: three-bubble load-use.
        cyc_b(mk(1,0, 5'd0,0, 5'd0,0, 5'd0, 0,0,0), ex(0,0,1), "b_reset");
        cyc_b(ld(5'd7), ex(0,0,0), "b_ld7");
        for (int i = 0; i < 3; i++) cyc_b(use_rs1(5'd7), ex(0,1,0), $sformatf("b_stall%0d", i));
        cyc_b(use_rs1(5'd7), ex(0,0,0), "b_stall_end");

        // Same with two busy cycles mid-stall: 3 stalls + 2 holds.
        n_stall = 0;
        n_hold  = 0;
        cyc_b(ld(5'd7), ex(0,0,0), "b_ld7_again");
        for (int i = 0; i < 6; i++) begin
            v = use_rs1(5'd7);
            v.busy = (i == 1 || i == 2);
            in_b = v;
            #1;
            n_stall += int'(b_stall);
            n_hold  += int'(b_hold);
            @(posedge clk);
            @(negedge clk);
        end
        check("b_busy_stalls", 64'(n_stall), 64'd3);
        check("b_busy_holds",  64'(n_hold),  64'd2);
        check("b_perf_sat",    64'(b_pstall), PERF_ON ? 64'd3 : 64'd0);

        // Reset while sb[5]=2.
        cyc_b(ld(5'd5), ex(0,0,0), "b_ld5");
        cyc_b(use_rs1(5'd5), ex(0,1,0), "b_stall5");
        v = use_rs1(5'd5);
        v.rst = 1'b1;
        cyc_b(v, ex(0,0,1), "b_rst_mid_stall");
        cyc_b(use_rs1(5'd5), ex(0,0,0), "b_after_rst");
        check("b_perf_stall_rst", 64'(b_pstall), 64'd0);
        check("b_perf_flush_rst", 64'(b_pflush), 64'd0);

        // Two flush cycles then three stalls.
        cyc_b(mk(0,0, 5'd0,0, 5'd0,0, 5'd0, 0,1,0), ex(0,0,1), "b_br");
        cyc_b(idle(), ex(0,0,1), "b_br_tail");
        cyc_b(idle(), ex(0,0,0), "b_br_done");
        cyc_b(ld(5'd7), ex(0,0,0), "b_ld7_perf");
        for (int i = 0; i < 3; i++) cyc_b(use_rs1(5'd7), ex(0,1,0), $sformatf("b_pstall%0d", i));
        cyc_b(use_rs1(5'd7), ex(0,0,0), "b_pstall_end");
        check("b_perf_stall", 64'(b_pstall), PERF_ON ? 64'd3 : 64'd0);
        check("b_perf_flush", 64'(b_pflush), PERF_ON ? 64'd2 : 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
